// File: rtl/chain_power_sched_pkg.sv
// Shared state codes, error codes and widths for the chain power scheduler.
package sched_pkg;

  localparam int PWR_W = 12;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_SORT = 3'd1;
  localparam state_t ST_ORDER     = 3'd2;
  localparam state_t ST_PACK      = 3'd3;
  localparam state_t ST_RUN       = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd1;
  localparam logic [1:0] ERR_DUP_ID      = 2'd2;
  localparam logic [1:0] ERR_OVER_BUDGET = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chain_power_sched_if.sv
// Chip-side and control signals of the chain power scheduler, bundled for one port.
interface chain_power_sched_if #(
  parameter int N_CHIP = 2
);
  logic                         start;
  logic [N_CHIP-1:0]            sort_finish;
  logic [4*N_CHIP-1:0]          chip_id;
  logic [4*N_CHIP-1:0]          power_value_upper;
  logic [4*N_CHIP-1:0]          power_value_lower;
  logic [N_CHIP-1:0]            test_en;
  logic                         busy;
  logic                         done;
  logic [1:0]                   err_code;
  logic [sched_pkg::PWR_W-1:0]  batch_power;

  modport master (
    output start, sort_finish, chip_id, power_value_upper, power_value_lower,
    input  test_en, busy, done, err_code, batch_power
  );

  modport slave (
    input  start, sort_finish, chip_id, power_value_upper, power_value_lower,
    output test_en, busy, done, err_code, batch_power
  );
endinterface

// File: rtl/chain_power_sched_id_order_scan.sv
// ORDER-phase scanner: one ID value k per cycle, appends the unique chip holding k to the order list.
module id_order_scan
  import sched_pkg::*;
#(
  parameter int N_CHIP = 2,
  parameter int IDX_W  = $clog2(N_CHIP),
  parameter int LEN_W  = $clog2(N_CHIP + 1)
) (
  input  logic                t_clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                scan_en,
  input  logic [3:0]          k,
  input  logic [4*N_CHIP-1:0] ids,
  output logic [IDX_W-1:0]    order_list [N_CHIP],
  output logic [LEN_W-1:0]    order_len,
  output logic                dup
);

  logic [N_CHIP-1:0] hit;
  logic [LEN_W-1:0]  hit_cnt;
  logic [IDX_W-1:0]  hit_idx;
  logic              dup_now;
  logic [IDX_W-1:0]  list_reg [N_CHIP];
  logic [LEN_W-1:0]  len_reg;
  logic              dup_reg;

  generate
    for (genvar gi = 0; gi < N_CHIP; gi++) begin : g_hit
      assign hit[gi] = (ids[4*gi +: 4] == k);
    end
  endgenerate

  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < N_CHIP; i++) begin
      if (hit[i]) begin
        hit_cnt = hit_cnt + LEN_W'(1);
        hit_idx = IDX_W'(i);
      end
    end
  end

  // A duplicate found on the last scanned value must reach the FSM in the same cycle.
  assign dup_now    = scan_en && (hit_cnt > LEN_W'(1));
  assign dup        = dup_reg | dup_now;
  assign order_len  = len_reg;
  assign order_list = list_reg;

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg <= '0;
      dup_reg <= 1'b0;
      for (int i = 0; i < N_CHIP; i++) list_reg[i] <= '0;
    end else if (clear) begin
      len_reg <= '0;
      dup_reg <= 1'b0;
    end else if (scan_en) begin
      if (dup_now) begin
        dup_reg <= 1'b1;
      end else if (hit_cnt == LEN_W'(1) && !dup_reg) begin
        list_reg[len_reg[IDX_W-1:0]] <= hit_idx;
        len_reg                      <= len_reg + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/chain_power_sched.sv
// Test-power scheduler: orders chips by ID, then grants test_en in batches under a power budget.
// Optional macro SCHED_TIMEOUT_EN bounds the wait for sort_finish by SORT_TIMEOUT cycles.
module chain_power_sched
  import sched_pkg::*;
#(
  parameter int N_CHIP       = 2,
  parameter int PWR_BUDGET   = 20,
  parameter int TEST_CYCLES  = 256,
  parameter int SORT_TIMEOUT = 1024
) (
  input logic                t_clk,
  input logic                rst_n,
  chain_power_sched_if.slave bus
);

  localparam int IDX_W = $clog2(N_CHIP);
  localparam int LEN_W = $clog2(N_CHIP + 1);
  localparam int CNT_W = $clog2(max3(TEST_CYCLES, SORT_TIMEOUT, 16) + 1);
  localparam int BW    = PWR_W + 1;
  localparam logic [BW-1:0] BUDGET = BW'(PWR_BUDGET);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [LEN_W-1:0]    ptr_reg;
  logic [4*N_CHIP-1:0] id_reg;
  logic [7:0]          pwr_reg [N_CHIP];
  logic [7:0]          chip_pwr [N_CHIP];
  logic [N_CHIP-1:0]   mask_reg;
  logic [N_CHIP-1:0]   test_en_reg;
  logic [PWR_W-1:0]    sum_reg;
  logic [PWR_W-1:0]    batch_power_reg;
  logic [1:0]          err_reg;

  logic [IDX_W-1:0]    order_list [N_CHIP];
  logic [LEN_W-1:0]    order_len;
  logic                scan_dup;

  logic [IDX_W-1:0]    cur_idx;
  logic [BW-1:0]       cur_pwr;
  logic [BW-1:0]       cand_sum;
  logic                list_left;
  logic                over_budget;
  logic                fits;
  logic                batch_empty;
  logic                all_sorted;

  generate
    for (genvar gi = 0; gi < N_CHIP; gi++) begin : g_pwr
      assign chip_pwr[gi] = {bus.power_value_upper[4*gi +: 4], bus.power_value_lower[4*gi +: 4]};
    end
  endgenerate

  id_order_scan #(
    .N_CHIP (N_CHIP),
    .IDX_W  (IDX_W),
    .LEN_W  (LEN_W)
  ) u_scan (
    .t_clk      (t_clk),
    .rst_n      (rst_n),
    .clear      (state_reg == ST_IDLE && bus.start),
    .scan_en    (state_reg == ST_ORDER),
    .k          (cnt_reg[3:0]),
    .ids        (id_reg),
    .order_list (order_list),
    .order_len  (order_len),
    .dup        (scan_dup)
  );

  always_comb begin
    cur_idx     = order_list[ptr_reg[IDX_W-1:0]];
    cur_pwr     = {{(BW-8){1'b0}}, pwr_reg[cur_idx]};
    cand_sum    = {1'b0, sum_reg} + cur_pwr;
    list_left   = (ptr_reg < order_len);
    over_budget = (cur_pwr > BUDGET);
    fits        = (cand_sum <= BUDGET);
    batch_empty = (mask_reg == '0);
    all_sorted  = &bus.sort_finish;
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      ptr_reg         <= '0;
      id_reg          <= '0;
      mask_reg        <= '0;
      test_en_reg     <= '0;
      sum_reg         <= '0;
      batch_power_reg <= '0;
      err_reg         <= ERR_NONE;
      for (int i = 0; i < N_CHIP; i++) pwr_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            err_reg   <= ERR_NONE;
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_SORT;
          end
        end
        ST_WAIT_SORT: begin
          if (all_sorted) begin
            id_reg    <= bus.chip_id;
            for (int i = 0; i < N_CHIP; i++) pwr_reg[i] <= chip_pwr[i];
            cnt_reg   <= '0;
            state_reg <= ST_ORDER;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(SORT_TIMEOUT - 1)) begin
            err_reg   <= ERR_TIMEOUT;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
`endif
        end
        ST_ORDER: begin
          // The full 16-value scan always runs; a duplicate only changes where it exits.
          if (scan_dup) err_reg <= ERR_DUP_ID;
          if (cnt_reg == CNT_W'(15)) begin
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            state_reg <= scan_dup ? ST_DONE : ST_PACK;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_PACK: begin
          if (list_left && over_budget && batch_empty) begin
            if (err_reg == ERR_NONE) err_reg <= ERR_OVER_BUDGET;
            ptr_reg <= ptr_reg + LEN_W'(1);
          end else if (list_left && fits) begin
            mask_reg[cur_idx] <= 1'b1;
            sum_reg           <= cand_sum[PWR_W-1:0];
            ptr_reg           <= ptr_reg + LEN_W'(1);
          end else if (!batch_empty) begin
            test_en_reg     <= mask_reg;
            batch_power_reg <= sum_reg;
            cnt_reg         <= '0;
            state_reg       <= ST_RUN;
          end else begin
            state_reg <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (cnt_reg == CNT_W'(TEST_CYCLES - 1)) begin
            test_en_reg     <= '0;
            batch_power_reg <= '0;
            mask_reg        <= '0;
            sum_reg         <= '0;
            state_reg       <= ST_PACK;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.test_en     = test_en_reg;
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.done        = (state_reg == ST_DONE);
  assign bus.err_code    = err_reg;
  assign bus.batch_power = batch_power_reg;

endmodule

// File: tb/tb_chain_power_sched.sv
// Directed bench for chain_power_sched (N_CHIP=2, budget 20, 256-cycle batches, SORT_TIMEOUT=16).
module tb_chain_power_sched;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  chain_power_sched_if #(.N_CHIP(N)) bus ();

  chain_power_sched #(
    .N_CHIP       (N),
    .PWR_BUDGET   (20),
    .TEST_CYCLES  (256),
    .SORT_TIMEOUT (16)
  ) dut (
    .t_clk (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic set_chips(input logic [3:0] id0, input logic [3:0] id1,
                           input logic [7:0] p0, input logic [7:0] p1);
    bus.chip_id           = {id1, id0};
    bus.power_value_upper = {p1[7:4], p0[7:4]};
    bus.power_value_lower = {p1[3:0], p0[3:0]};
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.test_en !== 2'b00) begin errors++; $display("FAIL reset_test_en: got %b expected 00", bus.test_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.err_code !== 2'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", bus.err_code); end
    checks++; if (bus.batch_power !== 12'd0) begin errors++; $display("FAIL reset_batch_power: got %0d expected 0", bus.batch_power); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
    $display("test_reset done");
  endtask

  task automatic test_one_batch();
    int lat;
    int n;
    set_chips(4'd1, 4'd0, 8'h05, 8'h07);
    bus.sort_finish = 2'b11;
    pulse_start();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL one_busy_rise: got %b expected 1", bus.busy); end
    lat = 1;
    while (bus.test_en === 2'b00 && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (lat !== 21) begin errors++; $display("FAIL one_run_latency: got %0d expected 21", lat); end
    checks++; if (bus.test_en !== 2'b11) begin errors++; $display("FAIL one_mask: got %b expected 11", bus.test_en); end
    checks++; if (bus.batch_power !== 12'd12) begin errors++; $display("FAIL one_batch_power: got %0d expected 12", bus.batch_power); end
    n = 0;
    while (bus.test_en === 2'b11 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n !== 256) begin errors++; $display("FAIL one_run_len: got %0d expected 256", n); end
    checks++; if (bus.test_en !== 2'b00 || bus.done !== 1'b0) begin errors++; $display("FAIL one_pack_gap: got test_en=%b done=%b expected 00/0", bus.test_en, bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL one_done: got %b expected 1", bus.done); end
    checks++; if (bus.err_code !== 2'd0) begin errors++; $display("FAIL one_err: got %0d expected 0", bus.err_code); end
    checks++; if (bus.batch_power !== 12'd0) begin errors++; $display("FAIL one_bp_idle: got %0d expected 0", bus.batch_power); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL one_busy_fall: got busy=%b done=%b expected 0/0", bus.busy, bus.done); end
    $display("test_one_batch: latency %0d run %0d", lat, n);
  endtask

  task automatic test_two_batches();
    int lat;
    int n;
    int g;
    set_chips(4'd1, 4'd0, 8'h0C, 8'h0A);
    bus.sort_finish = 2'b11;
    pulse_start();
    lat = 1;
    while (bus.test_en === 2'b00 && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (bus.test_en !== 2'b10) begin errors++; $display("FAIL two_first_mask: got %b expected 10", bus.test_en); end
    checks++; if (bus.batch_power !== 12'd10) begin errors++; $display("FAIL two_first_bp: got %0d expected 10", bus.batch_power); end
    n = 0;
    while (bus.test_en === 2'b10 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n !== 256) begin errors++; $display("FAIL two_first_len: got %0d expected 256", n); end
    g = 0;
    while (bus.test_en === 2'b00 && g < 10) begin @(negedge clk); g++; end
    checks++; if (g !== 2) begin errors++; $display("FAIL two_gap: got %0d expected 2", g); end
    checks++; if (bus.test_en !== 2'b01) begin errors++; $display("FAIL two_second_mask: got %b expected 01", bus.test_en); end
    checks++; if (bus.batch_power !== 12'd12) begin errors++; $display("FAIL two_second_bp: got %0d expected 12", bus.batch_power); end
    n = 0;
    while (bus.test_en === 2'b01 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n !== 256) begin errors++; $display("FAIL two_second_len: got %0d expected 256", n); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.err_code !== 2'd0) begin errors++; $display("FAIL two_done: got done=%b err=%0d expected 1/0", bus.done, bus.err_code); end
    @(negedge clk);
    $display("test_two_batches: gap %0d", g);
  endtask

  task automatic test_dup_back_to_back();
    int n;
    set_chips(4'd3, 4'd3, 8'h05, 8'h07);
    bus.sort_finish = 2'b11;
    bus.start = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL dup_busy: got %b expected 1", bus.busy); end
    repeat (16) @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dup_done_early: got %b expected 0", bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL dup_done: got %b expected 1", bus.done); end
    checks++; if (bus.err_code !== 2'd2) begin errors++; $display("FAIL dup_err: got %0d expected 2", bus.err_code); end
    checks++; if (bus.test_en !== 2'b00) begin errors++; $display("FAIL dup_test_en: got %b expected 00", bus.test_en); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dup_idle_cycle: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.err_code !== 2'd0) begin errors++; $display("FAIL dup_retrigger: got busy=%b err=%0d expected 1/0", bus.busy, bus.err_code); end
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 1'b1 || bus.err_code !== 2'd2) begin errors++; $display("FAIL dup_second_run: got done=%b err=%0d expected 1/2", bus.done, bus.err_code); end
    @(negedge clk);
    $display("test_dup_back_to_back: second done after %0d", n);
  endtask

  task automatic test_budget_skip();
    int lat;
    int n;
    logic bad;
    set_chips(4'd1, 4'd0, 8'h05, 8'h20);
    bus.sort_finish = 2'b11;
    pulse_start();
    lat = 1;
    while (bus.test_en === 2'b00 && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (bus.test_en !== 2'b01) begin errors++; $display("FAIL skip_mask: got %b expected 01", bus.test_en); end
    checks++; if (bus.batch_power !== 12'd5) begin errors++; $display("FAIL skip_bp: got %0d expected 5", bus.batch_power); end
    checks++; if (bus.err_code !== 2'd3) begin errors++; $display("FAIL skip_err_run: got %0d expected 3", bus.err_code); end
    n = 0;
    while (bus.test_en === 2'b01 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n !== 256) begin errors++; $display("FAIL skip_len: got %0d expected 256", n); end
    bad = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 10) begin
      if (bus.test_en !== 2'b00) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL skip_no_regrant: got %b expected 0", bad); end
    checks++; if (bus.done !== 1'b1 || bus.err_code !== 2'd3) begin errors++; $display("FAIL skip_done: got done=%b err=%0d expected 1/3", bus.done, bus.err_code); end
    @(negedge clk);
    $display("test_budget_skip: done after %0d", n);
  endtask

  task automatic test_sort_wait();
`ifdef SCHED_TIMEOUT_EN
    set_chips(4'd1, 4'd0, 8'h05, 8'h07);
    bus.sort_finish = 2'b01;
    pulse_start();
    repeat (15) @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.err_code !== 2'd1) begin errors++; $display("FAIL timeout_done: got done=%b err=%0d expected 1/1", bus.done, bus.err_code); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b expected 0", bus.busy); end
    $display("test_sort_wait: timeout path");
`else
    int n;
    logic seen_done;
    set_chips(4'd1, 4'd0, 8'h05, 8'h07);
    bus.sort_finish = 2'b01;
    pulse_start();
    seen_done = 1'b0;
    repeat (64) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL wait_no_done: got %b expected 0", seen_done); end
    checks++; if (bus.busy !== 1'b1 || bus.err_code !== 2'd0) begin errors++; $display("FAIL wait_still_busy: got busy=%b err=%0d expected 1/0", bus.busy, bus.err_code); end
    bus.sort_finish = 2'b11;
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (bus.done !== 1'b1 || bus.err_code !== 2'd0) begin errors++; $display("FAIL wait_release_done: got done=%b err=%0d expected 1/0", bus.done, bus.err_code); end
    @(negedge clk);
    $display("test_sort_wait: indefinite wait, released after %0d", n);
`endif
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int bad;
    set_chips(4'd1, 4'd0, 8'h05, 8'h07);
    bus.sort_finish = 2'b11;
    pulse_start();
    lat = 1;
    while (bus.test_en === 2'b00 && lat < 100) begin @(negedge clk); lat++; end
    repeat (99) @(negedge clk);
    checks++; if (bus.test_en !== 2'b11) begin errors++; $display("FAIL rst_run100_mask: got %b expected 11", bus.test_en); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.test_en !== 2'b00) begin errors++; $display("FAIL rst_async_test_en: got %b expected 00", bus.test_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.batch_power !== 12'd0) begin errors++; $display("FAIL rst_async_bp: got %0d expected 0", bus.batch_power); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.test_en !== 2'b00 || bus.done !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_stays_idle: got %0d active cycles expected 0", bad); end
    $display("test_reset_mid_run done");
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.start             = 1'b0;
    bus.sort_finish       = '0;
    bus.chip_id           = '0;
    bus.power_value_upper = '0;
    bus.power_value_lower = '0;
    test_reset();
    test_one_batch();
    test_two_batches();
    test_dup_back_to_back();
    test_budget_skip();
    test_sort_wait();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
